regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be: XLEN, 32, data width; ADDR_W, 5, register index width.
REQ-002 Port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port reset  in  1  asynchronous, active-high reset.
REQ-004 Ports alu_valid in 1, alu_rd in ADDR_W, alu_data in XLEN, alu_ready out 1: ALU writeback requester.
REQ-005 Ports mem_valid in 1, mem_rd in ADDR_W, mem_data in XLEN, mem_ready out 1: load writeback requester.
REQ-006 Ports reg_write out 1, rd out ADDR_W, write_data out XLEN: drive the register file write port directly.
REQ-007 Ports fwd_rs1, fwd_rs2 in ADDR_W; fwd_hit1, fwd_hit2 out 1; fwd_data1, fwd_data2 out XLEN: forwarding query of the in-flight write.

Function
REQ-008 A request SHALL transfer on a cycle where valid and ready are both high (handshake); valid SHALL NOT depend on ready.
REQ-009 ready outputs SHALL be combinational from the valid, rd and arbitration state only; the block SHALL never assert ready to a requester whose valid is low.
REQ-010 Exactly one request with rd != 0 SHALL be granted per cycle; the granted request SHALL be captured in an output register (out_valid, out_rd, out_data).
REQ-011 Latency: a request granted in cycle N SHALL appear as reg_write=1 with its rd/write_data in cycle N+1, for exactly one cycle.
REQ-012 With no grant in cycle N, reg_write SHALL be 0 in cycle N+1; rd/write_data hold their previous values.
REQ-013 Arbitration: single valid nonzero-rd request SHALL be granted; both valid with nonzero rd SHALL be resolved round-robin via a 1-bit last_grant (0=ALU, 1=MEM), granting the requester not last granted.
REQ-014 last_grant SHALL update only on a contended grant (both valid, both rd != 0).
REQ-015 A request with rd == 0 SHALL be accepted (ready=1) in the same cycle, discarded, never written, and SHALL NOT affect last_grant nor block the other requester.
REQ-016 Both requesters targeting the same nonzero rd SHALL be serialised per REQ-013; the later-granted value SHALL be the final register contents.
REQ-017 fwd_hitK SHALL be 1 iff out_valid=1 and out_rd == fwd_rsK and fwd_rsK != 0; fwd_dataK SHALL equal out_data when hit, else 0.
REQ-018 A losing requester holding valid SHALL be granted no later than the next cycle (max wait 1 cycle under continuous contention).

Reset
REQ-019 reset asserted SHALL immediately force out_valid=0 (reg_write=0), out_rd=0, out_data=0, last_grant=1 (first contended grant goes to ALU).
REQ-020 During reset alu_ready and mem_ready SHALL be 0; no transfer SHALL occur.
REQ-021 A grant captured the cycle before reset asserts SHALL be lost; the register file SHALL not be written.
REQ-022 Operation SHALL resume on the first rising clk edge after reset deasserts.

Structure
REQ-023 XLEN, ADDR_W, NUM_REGS (32) and the requester-id enum (REQ_ALU=0, REQ_MEM=1) SHALL live in shared package regfile_pkg.
REQ-024 The 2-way round-robin grant logic SHALL be a separate sub-module rf_rr_arb (inputs req[1:0], last_grant state; output grant[1:0]).

Verification
REQ-025 Only alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle 1 -> alu_ready=1 cycle 1; reg_write=1, rd=5, write_data=0xDEADBEEF cycle 2; reg_write=0 cycle 3.
REQ-026 After reset, both valid for 3 cycles (alu_rd=3/0x11, mem_rd=4/0x22, held) -> grants ALU, MEM, ALU; writes rd=3, 4, 3 in cycles 2-4.
REQ-027 mem_valid, mem_rd=0 with alu_valid, alu_rd=7 same cycle -> both ready=1; next cycle only rd=7 written; last_grant unchanged.
REQ-028 Both valid, rd=9, alu_data=0xA, mem_data=0xB, after reset -> rd=9/0xA then rd=9/0xB; final regfile[9]=0xB.
REQ-029 Write to rd=12 in flight, fwd_rs1=12, fwd_rs2=0 -> fwd_hit1=1, fwd_data1=value, fwd_hit2=0, fwd_data2=0.
REQ-030 reset asserted mid-cycle with write pending -> reg_write drops to 0 before the next clk edge; both ready=0 until reset deasserts.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and requester ids for the register-file writeback arbiter.
// Pure definitions: no logic, no latency, no flow control.
package regfile_pkg;
    localparam int XLEN     = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, register-file write and forwarding query bundle.
// master = requesters/regfile side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int XLEN   = regfile_pkg::XLEN,
    parameter int ADDR_W = regfile_pkg::ADDR_W
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]   mem_data;
    logic              mem_ready;
    logic              reg_write;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   write_data;
    logic [ADDR_W-1:0] fwd_rs1;
    logic [ADDR_W-1:0] fwd_rs2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [XLEN-1:0]   fwd_data1;
    logic [XLEN-1:0]   fwd_data2;

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_rs1, fwd_rs2,
        output alu_ready, mem_ready, reg_write, rd, write_data,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_rs1, fwd_rs2,
        input  alu_ready, mem_ready, reg_write, rd, write_data,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
endinterface

// File: rtl/rf_rr_arb.sv
// Two-way round-robin grant, purely combinational (0 cycles).
// Uncontended requests pass straight through; contention goes to the requester not last granted.
module rf_rr_arb
    import regfile_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last_grant,
    output logic [1:0] grant
);
    always_comb begin
        grant = req;
        if (req[REQ_ALU] && req[REQ_MEM]) begin
            grant = 2'b00;
            if (last_grant == REQ_MEM) begin
                grant[REQ_ALU] = 1'b1;
            end else begin
                grant[REQ_MEM] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto one regfile write port; 1-cycle latency, forwards the in-flight write.
// Backpressure: ready is combinational; a contended loser waits at most one cycle, rd==0 requests are sunk at once.
module regfile_write_arbiter #(
    parameter int XLEN   = regfile_pkg::XLEN,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_arbiter_if.slave bus
);
    import regfile_pkg::*;

    logic              alu_rd_zero;
    logic              mem_rd_zero;
    logic [1:0]        req;
    logic [1:0]        grant;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_rd_q,    out_rd_d;
    logic [XLEN-1:0]   out_data_q,  out_data_d;
    req_id_e           last_grant_q, last_grant_d;

    assign alu_rd_zero  = (bus.alu_rd == '0);
    assign mem_rd_zero  = (bus.mem_rd == '0);
    assign req[REQ_ALU] = bus.alu_valid && !alu_rd_zero;
    assign req[REQ_MEM] = bus.mem_valid && !mem_rd_zero;

    rf_rr_arb u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // x0 writes are swallowed here so they never occupy the write port.
    assign bus.alu_ready = !reset && bus.alu_valid && (alu_rd_zero || grant[REQ_ALU]);
    assign bus.mem_ready = !reset && bus.mem_valid && (mem_rd_zero || grant[REQ_MEM]);

    always_comb begin
        out_valid_d  = |grant;
        out_rd_d     = out_rd_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;
        if (grant[REQ_ALU]) begin
            out_rd_d   = bus.alu_rd;
            out_data_d = bus.alu_data;
        end else if (grant[REQ_MEM]) begin
            out_rd_d   = bus.mem_rd;
            out_data_d = bus.mem_data;
        end
        if (&req) begin
            last_grant_d = grant[REQ_MEM] ? REQ_MEM : REQ_ALU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_rd_q     <= '0;
            out_data_q   <= '0;
            last_grant_q <= REQ_MEM;
        end else begin
            out_valid_q  <= out_valid_d;
            out_rd_q     <= out_rd_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.reg_write  = out_valid_q;
    assign bus.rd         = out_rd_q;
    assign bus.write_data = out_data_q;

    assign bus.fwd_hit1  = out_valid_q && (out_rd_q == bus.fwd_rs1) && (bus.fwd_rs1 != '0);
    assign bus.fwd_hit2  = out_valid_q && (out_rd_q == bus.fwd_rs2) && (bus.fwd_rs2 != '0);
    assign bus.fwd_data1 = bus.fwd_hit1 ? out_data_q : '0;
    assign bus.fwd_data2 = bus.fwd_hit2 ? out_data_q : '0;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_regfile_write_arbiter;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] rf_model [32];

    regfile_write_arbiter_if bus_if ();

    regfile_write_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every negedge, reg_write must match the scoreboard head for this cycle.
    initial begin
        exp_t e;
        logic exp_now;
        forever begin
            @(negedge clk);
            exp_now = (sb_q.size() != 0) && (sb_q[0].cyc == cyc);
            chk("reg_write", 32'(bus_if.reg_write), 32'(exp_now));
            if (exp_now) begin
                e = sb_q.pop_front();
                chk("write_rd", 32'(bus_if.rd), 32'(e.rd));
                chk("write_data", bus_if.write_data, e.data);
            end
            if (bus_if.reg_write === 1'b1) rf_model[bus_if.rd] = bus_if.write_data;
        end
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        bus_if.alu_valid = av;
        bus_if.alu_rd    = ard;
        bus_if.alu_data  = ad;
        bus_if.mem_valid = mv;
        bus_if.mem_rd    = mrd;
        bus_if.mem_data  = md;
    endtask

    // One cycle of stimulus; an expected write lands one cycle after the grant.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic exp_ar, input logic exp_mr,
                        input logic exp_wr, input logic [4:0] exp_rd, input logic [31:0] exp_d,
                        input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        drive(av, ard, ad, mv, mrd, md);
        if (exp_wr) begin
            e.cyc  = cyc + 1;
            e.rd   = exp_rd;
            e.data = exp_d;
            sb_q.push_back(e);
        end
        @(negedge clk);
        chk({tag, "_alu_ready"}, 32'(bus_if.alu_ready), 32'(exp_ar));
        chk({tag, "_mem_ready"}, 32'(bus_if.mem_ready), 32'(exp_mr));
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        bus_if.fwd_rs1 = 5'd0;
        bus_if.fwd_rs2 = 5'd0;
        drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        foreach (rf_model[i]) rf_model[i] = 32'h0;

        // Reset state with both requesters valid.
        @(negedge clk);
        chk("rst_rd", 32'(bus_if.rd), 32'h0);
        chk("rst_write_data", bus_if.write_data, 32'h0);
        chk("rst_alu_ready", 32'(bus_if.alu_ready), 32'h0);
        chk("rst_mem_ready", 32'(bus_if.mem_ready), 32'h0);
        chk("rst_fwd_hit1", 32'(bus_if.fwd_hit1), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Single ALU write, then hold of rd/write_data after reg_write drops.
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1, 5'd5, 32'hDEADBEEF, "single");
        idle("single_i1");
        idle("single_i2");
        chk("hold_rd", 32'(bus_if.rd), 32'd5);
        chk("hold_write_data", bus_if.write_data, 32'hDEADBEEF);

        // Round-robin under continuous contention: ALU, MEM, ALU.
        reset_pulse();
        step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 0, 1, 5'd3, 32'h11, "rr1");
        step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 1, 1, 5'd4, 32'h22, "rr2");
        step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 1, 0, 1, 5'd3, 32'h11, "rr3");
        idle("rr_i");

        // Same rd from both: serialised, MEM value last; lone grant keeps last_grant=ALU.
        reset_pulse();
        step(1, 5'd9, 32'hA, 1, 5'd9, 32'hB, 1, 0, 1, 5'd9, 32'hA, "same1");
        step(0, 0, 0, 1, 5'd9, 32'hB, 0, 1, 1, 5'd9, 32'hB, "same2");
        step(1, 5'd1, 32'h100, 1, 5'd2, 32'h200, 0, 1, 1, 5'd2, 32'h200, "lg_hold");
        idle("same_i");
        chk("final_rf9", rf_model[9], 32'hB);

        // rd==0 requests are accepted, never written, and leave last_grant alone.
        reset_pulse();
        step(1, 5'd7, 32'h77, 1, 5'd0, 32'h99, 1, 1, 1, 5'd7, 32'h77, "rd0_mem");
        step(1, 5'd8, 32'h88, 1, 5'd10, 32'hAA, 1, 0, 1, 5'd8, 32'h88, "lg_keep");
        step(1, 5'd0, 32'h5, 0, 0, 0, 1, 0, 0, 0, 0, "rd0_alu");
        step(1, 5'd0, 32'h1, 1, 5'd0, 32'h2, 1, 1, 0, 0, 0, "rd0_both");
        idle("rd0_i");

        // Forwarding of the in-flight write.
        bus_if.fwd_rs1 = 5'd12;
        bus_if.fwd_rs2 = 5'd0;
        step(1, 5'd12, 32'hCAFEF00D, 0, 0, 0, 1, 0, 1, 5'd12, 32'hCAFEF00D, "fwd");
        idle("fwd_i1");
        chk("fwd_hit1", 32'(bus_if.fwd_hit1), 32'h1);
        chk("fwd_data1", bus_if.fwd_data1, 32'hCAFEF00D);
        chk("fwd_hit2", 32'(bus_if.fwd_hit2), 32'h0);
        chk("fwd_data2", bus_if.fwd_data2, 32'h0);
        bus_if.fwd_rs1 = 5'd13;
        #1;
        chk("fwd_miss_hit1", 32'(bus_if.fwd_hit1), 32'h0);
        chk("fwd_miss_data1", bus_if.fwd_data1, 32'h0);
        bus_if.fwd_rs1 = 5'd12;
        idle("fwd_i2");
        chk("fwd_idle_hit1", 32'(bus_if.fwd_hit1), 32'h0);

        // Reset arriving with a write in flight: the write is dropped immediately.
        reset_pulse();
        step(1, 5'd20, 32'h5555AAAA, 1, 5'd21, 32'h66666666, 1, 0, 0, 0, 0, "pend");
        @(posedge clk);
        #1;
        chk("pend_reg_write", 32'(bus_if.reg_write), 32'h1);
        chk("pend_rd", 32'(bus_if.rd), 32'd20);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_reg_write", 32'(bus_if.reg_write), 32'h0);
        chk("midrst_rd", 32'(bus_if.rd), 32'h0);
        chk("midrst_write_data", bus_if.write_data, 32'h0);
        chk("midrst_alu_ready", 32'(bus_if.alu_ready), 32'h0);
        chk("midrst_mem_ready", 32'(bus_if.mem_ready), 32'h0);
        @(negedge clk);
        chk("inrst_alu_ready", 32'(bus_if.alu_ready), 32'h0);
        chk("inrst_mem_ready", 32'(bus_if.mem_ready), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Resume after reset: first contended grant goes to ALU again.
        step(1, 5'd20, 32'h5555AAAA, 1, 5'd21, 32'h66666666, 1, 0, 1, 5'd20, 32'h5555AAAA, "resume1");
        step(0, 0, 0, 1, 5'd21, 32'h66666666, 0, 1, 1, 5'd21, 32'h66666666, "resume2");
        idle("resume_i1");
        idle("resume_i2");

        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
